sfx_tone_sequencer: RTL and testbench
=====================================

Name: sfx_tone_sequencer

Overview:
- Parametrised, multi-channel sound-effect player for the game audio path; replaces the ad-hoc note-divider muxing at top level.
- Game logic raises per-channel trigger levels (ball/paddle hit, brick break, miss, ...).
- Block arbitrates by priority, plays the selected channel's tone for a programmed duration through an internal sine LUT, and drives the 4-bit DAC sample bus.

Parameters:
- NUM_CH, 2, number of trigger channels; index NUM_CH-1 has highest priority.
- SAMPLE_W, 4, output sample width.
- ADDR_W, 5, sine LUT address width (32 samples/period).
- STEP_W, 16, width of per-channel step period (clk cycles per LUT step).
- DUR_W, 10, width of per-channel duration (ticks).
- TICK_DIV, 50000, clk cycles per duration tick (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock (50 MHz).
- reset_button  in  1  asynchronous, active-high reset.
- trig  in  NUM_CH  per-channel request levels; rising edge = request.
- mute  in  1  forces tono to midscale; sequencing unaffected.
- step_cfg  in  NUM_CH*STEP_W  flattened step periods, channel i at [i*STEP_W +: STEP_W].
- dur_cfg  in  NUM_CH*DUR_W  flattened durations in ticks.
- tono  out  SAMPLE_W  sample to DAC.
- busy  out  1  high while a channel plays.
- active_ch  out  CH_W  channel playing (CH_W = max(1, clog2(NUM_CH))).
- done  out  1  one-cycle pulse when a note ends naturally.

Behaviour:
- Reset: state IDLE; tono = 2^(SAMPLE_W-1) (8); busy=0; active_ch=0; done=0; pending=0; LUT address, step, tick and duration counters = 0; trig edge register = 0.
- Edge detect: trig_q <= trig; rise = trig & ~trig_q. Config is sampled when a channel starts; later changes take effect on the next start only.
- Free-running tick counter wraps at TICK_DIV-1; tick strobe on the wrap cycle.
- FSM IDLE/PLAY:
  - IDLE: on any rise with nonzero duration, start the highest-index such channel. Load dur_cnt = dur_cfg[ch], step_cnt=0, addr=0. busy=1 next cycle. Other simultaneous rises set their pending bits.
  - PLAY: step_cnt counts 0..step_cfg[ch]-1, then addr <= addr+1 (wraps 2^ADDR_W-1 -> 0). Step value 0 is treated as 1.
  - PLAY: on each tick, dur_cnt decrements. On the tick where dur_cnt==1, pulse done, clear busy, return to IDLE.
- Preemption in PLAY:
  - Rise on a higher index restarts with that channel (reload dur, addr=0). The preempted channel is dropped, not pended, and no done pulse is issued.
  - Rise on the same index retriggers: dur reloaded, phase kept.
  - Rise on a lower index sets its pending bit.
- Pending: on natural end, if pending!=0, the cycle after done starts the highest pending channel and clears its bit (busy low for exactly that one cycle). The pending bit of a channel that starts by any path is cleared.
- Zero-duration request: ignored entirely (not started, not pended).
- Simultaneous end-tick and new rise: the rise is treated as arriving in IDLE, after the ending note. It competes with pending; highest index wins.
- tono latency: sine_lut is registered, so tono follows addr by 1 cycle. A trig rise sampled at edge N gives busy at N+1 and the LUT[0] sample on tono at N+2.
- tono = midscale when IDLE or mute=1.
- Reset mid-note: immediate return to reset values; no done pulse.

Decomposition:
- Shared package holds:
  - MIDSCALE
  - FSM state encoding (IDLE=0, PLAY=1)
  - CH_W derivation
  - default note step constants for the 50 MHz clock: DO 0x2EA, RE 0x299, MI 0x250, SOL 0x1F2 (steps per 1/32 period, matching C/D/E/G).
- One sub-module, sine_lut: 2^ADDR_W x SAMPLE_W registered ROM, unsigned offset-binary sine.
- Arbiter (highest-set-bit priority encoder) stays inline as a function.

Test Plan (NUM_CH=2, TICK_DIV=10, step_cfg={4,2}, dur_cfg={3,5}):
- Reset and idle: hold reset 3 cycles then release -> tono=8, busy=0, done=0; stays so for 100 cycles with trig=0.
- Single note: pulse trig[0] -> busy at +1 cycle, active_ch=0. addr advances every 2 cycles; tono = LUT[k] one cycle after addr=k. done pulse after 5 ticks (on the 5th tick wrap after start), then busy=0 and tono=8.
- Preemption: start ch0, 20 cycles later rise trig[1] -> active_ch=1, addr restarts at 0, step every 4 cycles. Ends after 3 ticks with a single done; ch0 never resumes.
- Pending: start ch1, rise trig[0] mid-note -> after ch1's done, ch0 starts the next cycle (busy low 1 cycle), plays 5 ticks, second done; pending=0 afterwards.
- Edge cases:
  - dur_cfg[0]=0 plus trig[0] rise -> no state change.
  - trig[1] held high -> only one note.
  - same-channel retrigger mid-note extends the note by a full duration.
  - step_cfg=0 -> addr advances every cycle.
- Mute and reset mid-note: mute=1 during PLAY -> tono=8 while busy/done timing is unchanged. Assert reset mid-note -> all outputs return to reset values in the same cycle; no done pulse.

Source files
------------

// File: rtl/sfx_tone_sequencer_pkg.sv
// Shared types and constants for the sound-effect tone sequencer.
package sfx_tone_sequencer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned midscale(input int unsigned w);
    return 1 << (w - 1);
  endfunction

  localparam int unsigned MIDSCALE = midscale(4);

  // Clocks per 1/32 tone period at 50 MHz for C, D, E and G.
  localparam logic [15:0] STEP_DO  = 16'h02EA;
  localparam logic [15:0] STEP_RE  = 16'h0299;
  localparam logic [15:0] STEP_MI  = 16'h0250;
  localparam logic [15:0] STEP_SOL = 16'h01F2;

endpackage

// File: rtl/sfx_tone_sequencer_if.sv
// Trigger/config/sample bundle between game logic and the tone sequencer.
interface sfx_tone_sequencer_if #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SAMPLE_W = 4,
  parameter int unsigned STEP_W   = 16,
  parameter int unsigned DUR_W    = 10,
  parameter int unsigned CH_W     = 1
);
  logic [NUM_CH-1:0]        trig;
  logic                     mute;
  logic [NUM_CH*STEP_W-1:0] step_cfg;
  logic [NUM_CH*DUR_W-1:0]  dur_cfg;
  logic [SAMPLE_W-1:0]      tono;
  logic                     busy;
  logic [CH_W-1:0]          active_ch;
  logic                     done;

  modport master (
    output trig, mute, step_cfg, dur_cfg,
    input  tono, busy, active_ch, done
  );

  modport slave (
    input  trig, mute, step_cfg, dur_cfg,
    output tono, busy, active_ch, done
  );
endinterface

// File: rtl/sfx_tone_sequencer_sine_lut.sv
// Registered sine ROM, unsigned offset-binary, one full period over the address range.
module sfx_tone_sequencer_sine_lut #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned SAMPLE_W = 4
) (
  input  logic                clk,
  input  logic [ADDR_W-1:0]   addr,
  output logic [SAMPLE_W-1:0] sample
);

  localparam logic [3:0] SINE32 [32] = '{
    4'd8,  4'd9,  4'd11, 4'd12, 4'd13, 4'd14, 4'd14, 4'd15,
    4'd15, 4'd15, 4'd14, 4'd14, 4'd13, 4'd12, 4'd11, 4'd9,
    4'd8,  4'd7,  4'd5,  4'd4,  4'd3,  4'd2,  4'd2,  4'd1,
    4'd1,  4'd1,  4'd2,  4'd2,  4'd3,  4'd4,  4'd5,  4'd7
  };

  // Other widths reuse the 32x4 table: top address bits index it, value is MSB-aligned.
  logic [4:0] idx;

  always_comb begin
    idx = 5'({addr, 5'b0} >> ADDR_W);
  end

  always_ff @(posedge clk) begin
    sample <= SAMPLE_W'({SINE32[idx], SAMPLE_W'(0)} >> 4);
  end

endmodule

// File: rtl/sfx_tone_sequencer.sv
// Priority-arbitrated multi-channel tone player driving the DAC sample bus.
module sfx_tone_sequencer
  import sfx_tone_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SAMPLE_W = 4,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned STEP_W   = 16,
  parameter int unsigned DUR_W    = 10,
  parameter int unsigned TICK_DIV = 50000
) (
  input logic                clk,
  input logic                reset_button,
  sfx_tone_sequencer_if.slave bus
);

  localparam int unsigned CH_W   = ch_width(NUM_CH);
  localparam int unsigned TICK_W = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(midscale(SAMPLE_W));

  state_t              state;
  logic [NUM_CH-1:0]   trig_q;
  logic [NUM_CH-1:0]   pending;
  logic [TICK_W-1:0]   tick_cnt;
  logic [DUR_W-1:0]    dur_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic [STEP_W-1:0]   step_lim;
  logic [ADDR_W-1:0]   addr;
  logic [CH_W-1:0]     cur_ch;
  logic                busy;
  logic                sound_on;
  logic                done;
  logic [SAMPLE_W-1:0] lut_sample;

  logic [NUM_CH-1:0]   nz;
  logic [NUM_CH-1:0]   rise_ok;
  logic [NUM_CH-1:0]   cand;
  logic [CH_W-1:0]     hi_rise;
  logic [CH_W-1:0]     hi_cand;
  logic [CH_W-1:0]     new_ch;
  logic [DUR_W-1:0]    new_dur;
  logic [STEP_W-1:0]   new_step;
  logic                tick;
  logic                preempt;

  function automatic logic [CH_W-1:0] pick_hi(input logic [NUM_CH-1:0] v);
    pick_hi = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (v[i]) pick_hi = CH_W'(i);
    end
  endfunction

  always_comb begin
    nz = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      nz[i] = |bus.dur_cfg[i*DUR_W +: DUR_W];
    end
    rise_ok  = bus.trig & ~trig_q & nz;
    cand     = (pending & nz) | rise_ok;
    hi_rise  = pick_hi(rise_ok);
    hi_cand  = pick_hi(cand);
    tick     = (tick_cnt == TICK_W'(TICK_DIV - 1));
    preempt  = (rise_ok != '0) && (hi_rise > cur_ch);
    // In PLAY a retrigger implies no higher rise, so hi_rise is then cur_ch.
    new_ch   = (state == IDLE) ? hi_cand : hi_rise;
    new_dur  = bus.dur_cfg[int'(new_ch)*DUR_W +: DUR_W];
    new_step = bus.step_cfg[int'(new_ch)*STEP_W +: STEP_W];
  end

  always_ff @(posedge clk or posedge reset_button) begin
    if (reset_button) begin
      state    <= IDLE;
      trig_q   <= '0;
      pending  <= '0;
      tick_cnt <= '0;
      dur_cnt  <= '0;
      step_cnt <= '0;
      step_lim <= '0;
      addr     <= '0;
      cur_ch   <= '0;
      busy     <= 1'b0;
      sound_on <= 1'b0;
      done     <= 1'b0;
    end else begin
      trig_q   <= bus.trig;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      sound_on <= busy;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (cand != '0) begin
            state    <= PLAY;
            busy     <= 1'b1;
            cur_ch   <= new_ch;
            dur_cnt  <= new_dur;
            step_lim <= (new_step == '0) ? STEP_W'(1) : new_step;
            step_cnt <= '0;
            addr     <= '0;
            pending  <= cand & ~(NUM_CH'(1) << new_ch);
          end
        end
        PLAY: begin
          if (step_cnt == step_lim - STEP_W'(1)) begin
            step_cnt <= '0;
            addr     <= addr + 1'b1;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
          // An end tick wins over any rise; those rises are arbitrated from IDLE.
          if (tick && dur_cnt == DUR_W'(1)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pending <= pending | rise_ok;
          end else if (preempt) begin
            cur_ch   <= new_ch;
            dur_cnt  <= new_dur;
            step_lim <= (new_step == '0) ? STEP_W'(1) : new_step;
            step_cnt <= '0;
            addr     <= '0;
            pending  <= (pending | rise_ok) & ~(NUM_CH'(1) << new_ch);
          end else begin
            pending <= pending | (rise_ok & ~(NUM_CH'(1) << cur_ch));
            if (rise_ok[cur_ch]) begin
              dur_cnt <= new_dur;
            end else if (tick) begin
              dur_cnt <= dur_cnt - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sfx_tone_sequencer_sine_lut #(
    .ADDR_W   (ADDR_W),
    .SAMPLE_W (SAMPLE_W)
  ) sine_lut (
    .clk    (clk),
    .addr   (addr),
    .sample (lut_sample)
  );

  // The ROM lags addr by one cycle, so hold midscale until it has a valid sample.
  assign bus.tono      = (bus.mute || !(busy && sound_on)) ? MID : lut_sample;
  assign bus.busy      = busy;
  assign bus.active_ch = cur_ch;
  assign bus.done      = done;

endmodule

// File: tb/tb_sfx_tone_sequencer.sv
// Randomised and directed bench for sfx_tone_sequencer against a cycle-level reference model.
module tb_sfx_tone_sequencer;
  import sfx_tone_sequencer_pkg::*;

  localparam int unsigned NUM_CH   = 2;
  localparam int unsigned SAMPLE_W = 4;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned STEP_W   = 16;
  localparam int unsigned DUR_W    = 10;
  localparam int unsigned TICK_DIV = 10;
  localparam int unsigned CH_W     = ch_width(NUM_CH);

  logic clk = 1'b0;
  logic reset_button;

  always #5 clk = ~clk;

  sfx_tone_sequencer_if #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W),
    .STEP_W   (STEP_W),
    .DUR_W    (DUR_W),
    .CH_W     (CH_W)
  ) bus ();

  sfx_tone_sequencer #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W),
    .ADDR_W   (ADDR_W),
    .STEP_W   (STEP_W),
    .DUR_W    (DUR_W),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk          (clk),
    .reset_button (reset_button),
    .bus          (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: note phase is elapsed cycles divided by the step period.
  logic [NUM_CH-1:0] m_trig_q;
  logic [NUM_CH-1:0] m_pend;
  int m_tick, m_rem, m_cyc, m_step, m_ch, m_prev_addr;
  bit m_busy, m_prev_busy, m_done;

  function automatic int lut_exp(input int k);
    real x;
    x = 8.0 + 7.0 * $sin(2.0 * 3.14159265358979 * k / 32.0);
    return int'($floor(x + 0.5));
  endfunction

  function automatic int dur_of(input int c);
    return int'(bus.dur_cfg[c*DUR_W +: DUR_W]);
  endfunction

  function automatic int step_of(input int c);
    return int'(bus.step_cfg[c*STEP_W +: STEP_W]);
  endfunction

  function automatic int hi(input logic [NUM_CH-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < NUM_CH; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_trig_q = '0; m_pend = '0; m_tick = 0; m_rem = 0; m_cyc = 0; m_step = 1;
    m_ch = 0; m_prev_addr = 0; m_busy = 0; m_prev_busy = 0; m_done = 0;
  endtask

  task automatic model_start(input int c);
    m_busy = 1;
    m_ch   = c;
    m_rem  = dur_of(c);
    m_step = (step_of(c) == 0) ? 1 : step_of(c);
    m_cyc  = 0;
  endtask

  task automatic model_step();
    logic [NUM_CH-1:0] nz, rise, cand;
    bit tick;
    int nc;
    for (int i = 0; i < NUM_CH; i++) nz[i] = (dur_of(i) != 0);
    rise     = bus.trig & ~m_trig_q & nz;
    m_trig_q = bus.trig;
    tick     = (m_tick == TICK_DIV - 1);
    m_tick   = tick ? 0 : m_tick + 1;
    m_prev_busy = m_busy;
    m_prev_addr = (m_cyc / m_step) % 32;
    m_done = 0;
    if (!m_busy) begin
      cand = (m_pend & nz) | rise;
      if (cand != '0) begin
        nc = hi(cand);
        model_start(nc);
        m_pend = cand;
        m_pend[nc] = 1'b0;
      end
    end else begin
      m_cyc++;
      if (tick && m_rem == 1) begin
        m_done = 1;
        m_busy = 0;
        m_pend = m_pend | rise;
      end else if (rise != '0 && hi(rise) > m_ch) begin
        nc = hi(rise);
        model_start(nc);
        m_pend = m_pend | rise;
        m_pend[nc] = 1'b0;
      end else begin
        if (rise[m_ch]) m_rem = dur_of(m_ch);
        else if (tick) m_rem--;
        rise[m_ch] = 1'b0;
        m_pend = m_pend | rise;
      end
    end
  endtask

  task automatic compare();
    int exp_tono;
    exp_tono = (bus.mute || !m_busy || !m_prev_busy) ? 8 : lut_exp(m_prev_addr);
    check("busy", bus.busy, m_busy);
    check("done", bus.done, m_done);
    check("active_ch", bus.active_ch, m_ch);
    check("tono", bus.tono, exp_tono);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse(input int c);
    bus.trig[c] = 1'b1;
    cycle();
    bus.trig[c] = 1'b0;
  endtask

  task automatic set_cfg(input int s0, input int s1, input int d0, input int d1);
    bus.step_cfg = {STEP_W'(s1), STEP_W'(s0)};
    bus.dur_cfg  = {DUR_W'(d1), DUR_W'(d0)};
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_tono"}, bus.tono, 8);
    check({tag, "_active_ch"}, bus.active_ch, 0);
  endtask

  initial begin
    int c;
    reset_button = 1'b1;
    bus.trig = '0;
    bus.mute = 1'b0;
    set_cfg(2, 4, 5, 3);
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_button = 1'b0;

    run(100);                                   // idle
    pulse(0); run(70);                          // single note on ch0
    pulse(0); run(20); pulse(1); run(60);       // preemption
    pulse(1); run(10); pulse(0); run(100);      // pending
    set_cfg(2, 4, 0, 3); pulse(0); run(20);     // zero duration ignored
    set_cfg(2, 4, 5, 3);
    bus.trig[1] = 1'b1; run(60); bus.trig[1] = 1'b0; run(5);
    pulse(0); run(25); pulse(0); run(80);       // same-channel retrigger
    set_cfg(0, 4, 5, 3); pulse(0); run(60);     // step 0 acts as 1
    set_cfg(2, 4, 5, 3);
    pulse(0); run(10); bus.mute = 1'b1; run(50); bus.mute = 1'b0;

    pulse(1); run(8);                           // asynchronous reset mid-note
    #2 reset_button = 1'b1;
    #1 check_reset_values("reset_mid");
    @(negedge clk);
    check_reset_values("reset_hold");
    model_reset();
    reset_button = 1'b0;
    run(5);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(299, 0) == 0) begin
        set_cfg($urandom_range(5, 0), $urandom_range(5, 0),
                $urandom_range(4, 0), $urandom_range(4, 0));
      end
      if ($urandom_range(19, 0) == 0) begin
        c = $urandom_range(NUM_CH - 1, 0);
        bus.trig[c] = ~bus.trig[c];
      end
      if ($urandom_range(149, 0) == 0) bus.mute = ~bus.mute;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
